// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchronizer, oversampled mid-bit sampling, valid/ready byte output.
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int DIV_RAW = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync_meta_q;
    logic                   rxs_q;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [SAMP_W-1:0]      samp_cnt_q, samp_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   dlv_q, dlv_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic tick;
    logic mid_start;
    logic mid_bit;

    assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
    assign mid_start = tick && (samp_cnt_q == SAMP_W'(OVERSAMPLE / 2 - 1));
    assign mid_bit   = tick && (samp_cnt_q == SAMP_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples the values from before the edge.
        if (!rst_n) begin
            sync_meta_q  <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            dlv_q        <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_meta_q  <= rx;
            rxs_q        <= sync_meta_q;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            dlv_q        <= dlv_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every _d takes a default before any branch, so no path can infer a latch.
        state_d      = state_q;
        div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
        samp_cnt_d   = tick ? samp_cnt_q + 1'b1 : samp_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        dlv_d        = 1'b0;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        // A pending byte from the previous stop sample; a same-cycle consume frees the slot.
        if (dlv_q) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
                parity_err_d = 1'b1;
            end else
`endif
            if (data_valid_q && !data_ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d    = START;
                    div_cnt_d  = '0;
                    samp_cnt_d = '0;
                    bit_idx_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (mid_start) begin
                    samp_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    samp_cnt_d = '0;
                    shift_d    = {rxs_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d  = bit_idx_q + 1'b1;
                    if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_bit) begin
                    samp_cnt_d = '0;
                    par_bad_d  = (^shift_q) ^ rxs_q;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (mid_bit) begin
                    samp_cnt_d = '0;
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else begin
                        dlv_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes go into a scoreboard queue, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int PE_TOTAL   = 1;
`else
    localparam int FRAME_BITS = 10;
    localparam int PE_TOTAL   = 0;
`endif
    // Start edge to visible data_valid: mid-stop sample plus synchronizer and deliver cycles.
    localparam int LAT_NOM = FRAME_BITS * BIT_CLKS - BIT_CLKS / 2 + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int  dv_rises      = 0;
    int  dv_hi         = 0;
    int  last_rise_cyc = 0;
    int  fe_cnt        = 0;
    int  ov_cnt        = 0;
    int  pe_cnt        = 0;
    bit  dv_prev       = 1'b0;
    bit  abort_tx      = 1'b0;
`ifdef UART_RX_PARITY_EN
    bit  par_flip      = 1'b0;
`endif

    uart_rx #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE      (BAUD),
        .OVERSAMPLE     (OS),
        .DATA_BITS      (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid && !dv_prev) begin
                dv_rises++;
                last_rise_cyc = cyc;
            end
            if (data_valid) dv_hi++;
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h, expected none", data);
                end else begin
                    check("sb_data", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            dv_prev = data_valid;
        end else begin
            dv_prev = 1'b0;
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [11:0] frame;
        int          nb;
`ifdef UART_RX_PARITY_EN
        frame = {1'b1, stop_bit, (^b) ^ par_flip, b, 1'b0};
        nb    = 11;
`else
        frame = {2'b11, stop_bit, b, 1'b0};
        nb    = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            rx = frame[i];
            for (int k = 0; k < BIT_CLKS; k++) begin
                drv();
                if (abort_tx) begin
                    rx = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic wait_empty(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            drv();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t_edge, rises0, hi0, fe0, ov0, pe0;

        rst_n      = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b1;
        idle(5);
        check("rst_data",       32'(data),       32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_errs",       32'({frame_err, overrun, parity_err}), 32'h0);
        rst_n = 1'b1;
        idle(20);

        // 0xA5 with ready high: single-cycle valid at the nominal latency.
        hi0 = dv_hi;
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_empty("a5_received", 200);
        check_range("a5_latency", last_rise_cyc - t0, LAT_NOM - 24, LAT_NOM + 24);
        check("a5_valid_width", 32'(dv_hi - hi0), 32'd1);
        check("a5_no_errors", 32'(fe_cnt + ov_cnt + pe_cnt), 32'd0);

        // 0x5C with ready low: valid holds until the consumer takes it.
        data_ready = 1'b0;
        exp_q.push_back(8'h5C);
        send_frame(8'h5C, 1'b1);
        idle(50);
        check("hold_valid", 32'(data_valid), 32'h1);
        check("hold_data",  32'(data),       32'h5C);
        data_ready = 1'b1;
        wait_empty("hold_consumed", 10);
        check("hold_cleared", 32'(data_valid), 32'h0);

        // 40-clock glitch: rejected at the mid-start sample.
        rises0 = dv_rises;
        fe0    = fe_cnt;
        rx     = 1'b0;
        t_edge = cyc;
        idle(10);
        check("glitch_busy", 32'(busy), 32'h1);
        idle(30);
        rx = 1'b1;
        while (busy && (cyc - t_edge) < 90) drv();
        check("glitch_busy_clear", 32'(busy), 32'h0);
        idle(400);
        check("glitch_no_data", 32'(dv_rises - rises0), 32'd0);
        check("glitch_no_err",  32'(fe_cnt - fe0), 32'd0);

        // 0x3C with a low stop bit and a 500-clock break, then 0x5A.
        rises0 = dv_rises;
        fe0    = fe_cnt;
        send_frame(8'h3C, 1'b0);
        idle(500 - BIT_CLKS);
        rx = 1'b1;
        idle(100);
        check("break_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("break_idle", 32'(busy), 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_empty("after_break_5a", 200);
        check("break_one_delivery", 32'(dv_rises - rises0), 32'd1);

        // Back-to-back 0x11, 0x22 with ready low: second byte overruns.
        data_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        check("overrun_pulse", 32'(ov_cnt - ov0), 32'd1);
        check("overrun_data",  32'(data),       32'h11);
        check("overrun_valid", 32'(data_valid), 32'h1);
        data_ready = 1'b1;
        wait_empty("overrun_consumed", 10);
        check("overrun_cleared", 32'(data_valid), 32'h0);

        // Reset pulse in the middle of data bit 3 of 0x33, then 0x7E.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
        fork
            send_frame(8'h33, 1'b1);
            begin
                idle(4 * BIT_CLKS + BIT_CLKS / 2);
                check("busy_before_reset", 32'(busy), 32'h1);
                rst_n = 1'b0;
                #1;
                check("mid_rst_data",  32'(data),       32'h0);
                check("mid_rst_valid", 32'(data_valid), 32'h0);
                check("mid_rst_busy",  32'(busy),       32'h0);
                check("mid_rst_errs",  32'({frame_err, overrun, parity_err}), 32'h0);
                idle(3);
                abort_tx = 1'b1;
                idle(2);
                rst_n = 1'b1;
            end
        join
        abort_tx = 1'b0;
        idle(50);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_empty("after_reset_7e", 200);
        check("reset_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x03 with a wrong parity bit, then with the correct one.
        rises0   = dv_rises;
        pe0      = pe_cnt;
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        par_flip = 1'b0;
        idle(50);
        check("parity_err_pulse", 32'(pe_cnt - pe0), 32'd1);
        check("parity_no_data",   32'(dv_rises - rises0), 32'd0);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1);
        wait_empty("parity_ok_03", 200);
`endif

        idle(20);
        check("total_frame_err",  32'(fe_cnt), 32'd1);
        check("total_overrun",    32'(ov_cnt), 32'd1);
        check("total_parity_err", 32'(pe_cnt), 32'(PE_TOTAL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
